puf_response_collector: RTL and testbench

- Sits directly downstream of the PDL PUF 6-input XOR output network and consumes its 1-bit xor_response.
- For each challenge, samples the response N_EVAL times and majority-votes a stable bit.
- Packs WORD_W voted bits into a response word, requesting the next challenge from the challenge generator between bits.
- Presents the completed word, plus an unstable-bit count, on a valid/ready handshake toward the host/UART side.

---
 rtl/puf_pkg.sv | 14 +
 rtl/puf_majority_voter.sv | 51 +++++
 rtl/puf_response_collector.sv | 123 ++++++++++++
 tb/tb_puf_response_collector.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
// Shared types and default sizing for the PUF response collector and its bench.
package puf_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        DECIDE = 2'd2,
        OUT    = 2'd3
    } puf_state_e;

    localparam int N_EVAL_DEF = 16;
    localparam int WORD_W_DEF = 32;

endpackage

// File: rtl/puf_majority_voter.sv
// Counts accepted samples and ones for one challenge; vote/unstable are valid once done has fired.
// Latency: done is combinational on the N_EVAL-th accepted sample; no backpressure (parent gates sample_en).
module puf_majority_voter
    import puf_pkg::*;
#(
    parameter  int N_EVAL = N_EVAL_DEF,
    localparam int CNT_W  = $clog2(N_EVAL + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic sample_en,
    input  logic sample,
    output logic vote,
    output logic unstable,
    output logic done
);

    logic [CNT_W-1:0] ones_cnt_q, ones_cnt_d;
    logic [CNT_W-1:0] eval_cnt_q, eval_cnt_d;
    logic [CNT_W:0]   ones_x2;

    always_comb begin
        ones_cnt_d = ones_cnt_q;
        eval_cnt_d = eval_cnt_q;
        if (clr) begin
            ones_cnt_d = '0;
            eval_cnt_d = '0;
        end else if (sample_en) begin
            ones_cnt_d = ones_cnt_q + CNT_W'(sample);
            eval_cnt_d = eval_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ones_cnt_q <= '0;
            eval_cnt_q <= '0;
        end else begin
            ones_cnt_q <= ones_cnt_d;
            eval_cnt_q <= eval_cnt_d;
        end
    end

    // Strict majority: a tie at N_EVAL/2 resolves to 0.
    assign ones_x2  = {ones_cnt_q, 1'b0};
    assign vote     = ones_x2 > (CNT_W + 1)'(N_EVAL);
    assign unstable = (ones_cnt_q != '0) && (ones_cnt_q != CNT_W'(N_EVAL));
    assign done     = sample_en && (eval_cnt_q == CNT_W'(N_EVAL - 1));

endmodule

// File: rtl/puf_response_collector.sv
// Collects WORD_W majority-voted PUF bits (one challenge each) into a word with an unstable-bit count.
// Latency: WORD_W*(N_EVAL+2) cycles minimum; word held in OUT until word_valid && word_ready.
module puf_response_collector
    import puf_pkg::*;
#(
    parameter  int N_EVAL = N_EVAL_DEF,
    parameter  int WORD_W = WORD_W_DEF,
    localparam int CNT_W  = $clog2(N_EVAL + 1),
    localparam int IDX_W  = $clog2(WORD_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              xor_response,
    input  logic              resp_valid,
    output logic              next_chal,
    output logic              busy,
    output logic [WORD_W-1:0] word_out,
    output logic [IDX_W:0]    unstable_cnt,
    output logic              word_valid,
    input  logic              word_ready
);

    puf_state_e        state_q, state_d;
    logic              next_chal_q, next_chal_d;
    logic              word_valid_q, word_valid_d;
    logic [WORD_W-1:0] word_out_q, word_out_d;
    logic [IDX_W:0]    unstable_cnt_q, unstable_cnt_d;
    logic [IDX_W:0]    unst_acc_q, unst_acc_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic [IDX_W:0]    acc_next;
    logic              voter_clr, sample_en, vote, unstable, done;

    // The next_chal cycle is the challenge settle window, so its sample is dropped.
    assign sample_en = (state_q == EVAL) && resp_valid && !next_chal_q;

    puf_majority_voter #(.N_EVAL(N_EVAL)) u_voter (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (voter_clr),
        .sample_en (sample_en),
        .sample    (xor_response),
        .vote      (vote),
        .unstable  (unstable),
        .done      (done)
    );

    always_comb begin
        state_d        = state_q;
        next_chal_d    = 1'b0;
        word_valid_d   = word_valid_q;
        word_out_d     = word_out_q;
        unstable_cnt_d = unstable_cnt_q;
        unst_acc_d     = unst_acc_q;
        bit_idx_d      = bit_idx_q;
        voter_clr      = 1'b0;
        acc_next       = unst_acc_q + (IDX_W + 1)'(unstable);
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = EVAL;
                    next_chal_d = 1'b1;
                    bit_idx_d   = '0;
                    unst_acc_d  = '0;
                    voter_clr   = 1'b1;
                end
            end
            EVAL: begin
                if (done) begin
                    state_d = DECIDE;
                end
            end
            DECIDE: begin
                word_out_d[bit_idx_q] = vote;
                unst_acc_d            = acc_next;
                if (bit_idx_q == IDX_W'(WORD_W - 1)) begin
                    unstable_cnt_d = acc_next;
                    word_valid_d   = 1'b1;
                    state_d        = OUT;
                end else begin
                    bit_idx_d   = bit_idx_q + IDX_W'(1);
                    voter_clr   = 1'b1;
                    next_chal_d = 1'b1;
                    state_d     = EVAL;
                end
            end
            OUT: begin
                if (word_ready) begin
                    word_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            next_chal_q    <= 1'b0;
            word_valid_q   <= 1'b0;
            word_out_q     <= '0;
            unstable_cnt_q <= '0;
            unst_acc_q     <= '0;
            bit_idx_q      <= '0;
        end else begin
            state_q        <= state_d;
            next_chal_q    <= next_chal_d;
            word_valid_q   <= word_valid_d;
            word_out_q     <= word_out_d;
            unstable_cnt_q <= unstable_cnt_d;
            unst_acc_q     <= unst_acc_d;
            bit_idx_q      <= bit_idx_d;
        end
    end

    assign next_chal    = next_chal_q;
    assign busy         = (state_q != IDLE);
    assign word_out     = word_out_q;
    assign unstable_cnt = unstable_cnt_q;
    assign word_valid   = word_valid_q;

endmodule

// File: tb/tb_puf_response_collector.sv
// Scoreboarded bench: expected word/unstable count queued at start, popped at the output handshake.
module tb_puf_response_collector;
    import puf_pkg::*;

    localparam int N     = N_EVAL_DEF;
    localparam int W     = WORD_W_DEF;
    localparam int IDX_W = $clog2(W);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             xor_response = 1'b0;
    logic             resp_valid = 1'b0;
    logic             next_chal;
    logic             busy;
    logic [W-1:0]     word_out;
    logic [IDX_W:0]   unstable_cnt;
    logic             word_valid;
    logic             word_ready = 1'b0;

    puf_response_collector #(.N_EVAL(N), .WORD_W(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .xor_response (xor_response),
        .resp_valid   (resp_valid),
        .next_chal    (next_chal),
        .busy         (busy),
        .word_out     (word_out),
        .unstable_cnt (unstable_cnt),
        .word_valid   (word_valid),
        .word_ready   (word_ready)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;
    int cyc   = 0;

    logic [W+IDX_W:0] sb_q[$];

    // Stimulus model state, shared between the driver and run_word.
    int mode     = 0;
    int chal_cnt = 0;
    int cur_bit  = 0;
    int k        = 0;
    bit in_bit   = 0;
    int ones_tab[W];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int ones_for(input int m, input int b);
        case (m)
            1:       return N / 2;
            2:       return (b % 2 == 0) ? 12 : 3;
            3:       return (b % 2 == 0) ? N : 0;
            5:       return ones_tab[b];
            default: return N;
        endcase
    endfunction

    // Driver: tracks accepted samples independently and shapes xor_response per bit.
    always @(negedge clk) begin
        bit rv;
        bit acc;
        if (next_chal) begin
            cur_bit = chal_cnt;
            chal_cnt++;
            k = 0;
            in_bit = 1;
        end
        rv = (mode == 4) ? bit'($urandom_range(0, 1)) : 1'b1;
        acc = rv && !next_chal && in_bit && (k < N);
        if (mode == 4)
            xor_response = (next_chal && rv) ? 1'b0 : 1'b1;
        else if (mode == 1)
            xor_response = (k % 2 == 0);
        else
            xor_response = (k < ones_for(mode, cur_bit));
        resp_valid = rv;
        if (acc) k++;
    end

    task automatic run_word(input int m, input int hold);
        logic [W-1:0]   ew;
        logic [IDX_W:0] eu;
        logic [W-1:0]   snap_w;
        logic [W+IDX_W:0] exp_e;
        int t0, waited, o;
        bit stable;
        ew = '0;
        eu = '0;
        if (m == 5)
            for (int i = 0; i < W; i++) ones_tab[i] = $urandom_range(0, N);
        for (int i = 0; i < W; i++) begin
            o = ones_for(m, i);
            ew[i] = (2 * o > N);
            if (o != 0 && o != N) eu++;
        end
        sb_q.push_back({eu, ew});
        @(negedge clk);
        mode = m;
        chal_cnt = 0;
        in_bit = 0;
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (!word_valid && waited < 5000) begin
            @(negedge clk);
            waited++;
        end
        check_vec("word_valid_timeout", 64'(word_valid), 64'd1);
        if (m != 4) check_vec("latency", 64'(cyc - t0 - 1), 64'(W * (N + 2)));
        check_vec("chal_pulses", 64'(chal_cnt), 64'(W));
        snap_w = word_out;
        stable = 1;
        for (int i = 0; i < hold; i++) begin
            start = (i == hold / 2);
            @(negedge clk);
            if (!word_valid || word_out !== snap_w) stable = 0;
        end
        start = 1'b0;
        if (hold > 0) check_vec("bp_stable", 64'(stable), 64'd1);
        exp_e = sb_q.pop_front();
        check_vec("word_out", 64'(word_out), 64'(exp_e[W-1:0]));
        check_vec("unstable_cnt", 64'(unstable_cnt), 64'(exp_e[W+IDX_W:W]));
        word_ready = 1'b1;
        @(negedge clk);
        word_ready = 1'b0;
        check_vec("valid_after_hs", 64'(word_valid), 64'd0);
        check_vec("busy_after_hs", 64'(busy), 64'd0);
        check_vec("word_retained", 64'(word_out), 64'(exp_e[W-1:0]));
        @(negedge clk);
        check_vec("idle_no_restart", 64'(busy), 64'd0);
    endtask

    initial begin
        int waited;
        repeat (3) @(negedge clk);
        check_vec("rst_busy", 64'(busy), 64'd0);
        check_vec("rst_valid", 64'(word_valid), 64'd0);
        check_vec("rst_next_chal", 64'(next_chal), 64'd0);
        check_vec("rst_word", 64'(word_out), 64'd0);
        check_vec("rst_unstable", 64'(unstable_cnt), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_word(0, 0);
        run_word(1, 0);
        run_word(2, 0);
        run_word(3, 20);
        run_word(4, 0);
        run_word(5, 3);

        // Abort a word at bit 10 with a one-cycle reset.
        @(negedge clk);
        mode = 2;
        chal_cnt = 0;
        in_bit = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (chal_cnt < 11 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        check_vec("reach_bit10", 64'(chal_cnt), 64'd11);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        in_bit = 0;
        check_vec("midrst_busy", 64'(busy), 64'd0);
        check_vec("midrst_valid", 64'(word_valid), 64'd0);
        check_vec("midrst_word", 64'(word_out), 64'd0);
        check_vec("midrst_unstable", 64'(unstable_cnt), 64'd0);
        repeat (2) @(negedge clk);
        run_word(5, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
